// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT RAM sequencer.
package ntt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_N  = 1024;
    localparam int unsigned DEFAULT_AW = $clog2(DEFAULT_N);
    localparam int unsigned MAX_BF_LAT = 7;
    localparam int unsigned WAIT_W     = $clog2(MAX_BF_LAT + 1);

endpackage

// File: rtl/ntt_pair_counter.sv
// Walks the Cooley-Tukey butterfly order: stage span d, block base j,
// offset k, and the per-block twiddle index.
module ntt_pair_counter #(
    parameter int unsigned N  = 1024,
    parameter int unsigned AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    output logic [AW-1:0] addr_a,
    output logic [AW-1:0] addr_b,
    output logic [AW-1:0] tw_idx,
    output logic          last
);

    logic [AW-1:0] d;
    logic [AW-1:0] j;
    logic [AW-1:0] k;
    logic [AW-1:0] tw;

    logic [AW:0] k_inc;
    logic [AW:0] j_step;
    logic        more_k;
    logic        more_j;
    logic        more_d;

    // One extra bit so j + 2d can reach N without wrapping.
    assign k_inc  = {1'b0, k} + (AW+1)'(1);
    assign j_step = {1'b0, j} + {d, 1'b0};
    assign more_k = k_inc < {1'b0, d};
    assign more_j = j_step < (AW+1)'(N);
    assign more_d = d > AW'(1);
    assign last   = !more_k && !more_j && !more_d;

    assign addr_a = j + k;
    assign addr_b = j + k + d;
    assign tw_idx = tw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d  <= '0;
            j  <= '0;
            k  <= '0;
            tw <= '0;
        end else if (clear) begin
            d  <= AW'(N / 2);
            j  <= '0;
            k  <= '0;
            tw <= AW'(1);
        end else if (advance) begin
            if (more_k) begin
                k <= k_inc[AW-1:0];
            end else if (more_j) begin
                j  <= j_step[AW-1:0];
                k  <= '0;
                tw <= tw + AW'(1);
            end else if (more_d) begin
                d  <= d >> 1;
                j  <= '0;
                k  <= '0;
                tw <= tw + AW'(1);
            end
        end
    end

endmodule

// File: rtl/ntt_ram_sequencer.sv
// In-place forward-NTT pass sequencer: read pair, wait for the butterfly,
// write the results back to the same two addresses.
module ntt_ram_sequencer
    import ntt_pkg::*;
#(
    parameter int unsigned N      = 1024,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned BF_LAT = 2,
    localparam int unsigned AW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ram_ena,
    output logic             ram_enb,
    output logic             ram_wea,
    output logic             ram_web,
    output logic [AW-1:0]    ram_addra,
    output logic [AW-1:0]    ram_addrb,
    output logic [WIDTH-1:0] ram_dia,
    output logic [WIDTH-1:0] ram_dib,
    output logic             bf_valid,
    output logic [AW-1:0]    tw_idx,
    input  logic [WIDTH-1:0] bf_res_a,
    input  logic [WIDTH-1:0] bf_res_b
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(BF_LAT - 1);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wcnt;
    logic [WAIT_W-1:0] wcnt_next;
    logic              clear;
    logic              advance;
    logic              last;

    ntt_pair_counter #(
        .N  (N),
        .AW (AW)
    ) u_pair_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .advance (advance),
        .addr_a  (ram_addra),
        .addr_b  (ram_addrb),
        .tw_idx  (tw_idx),
        .last    (last)
    );

    assign ram_dia = bf_res_a;
    assign ram_dib = bf_res_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        clear      = 1'b0;
        advance    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        ram_ena    = 1'b0;
        ram_enb    = 1'b0;
        ram_wea    = 1'b0;
        ram_web    = 1'b0;
        bf_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = RD;
                end
            end
            RD: begin
                busy       = 1'b1;
                ram_ena    = 1'b1;
                ram_enb    = 1'b1;
                wcnt_next  = WAIT_LOAD;
                state_next = WAIT;
            end
            WAIT: begin
                busy     = 1'b1;
                // RAM read data is valid only in the first wait cycle.
                bf_valid = (wcnt == WAIT_LOAD);
                if (wcnt == '0) begin
                    state_next = WR;
                end else begin
                    wcnt_next = wcnt - WAIT_W'(1);
                end
            end
            WR: begin
                busy       = 1'b1;
                ram_ena    = 1'b1;
                ram_enb    = 1'b1;
                ram_wea    = 1'b1;
                ram_web    = 1'b1;
                advance    = 1'b1;
                state_next = last ? DONE : RD;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ntt_ram_sequencer.sv
// Scoreboard bench: N=8 pass with RAM + butterfly model, plus N=1024 timing
// instances at BF_LAT 1, 3 and 7.
module tb_ntt_ram_sequencer;

    localparam int N   = 8;
    localparam int PER = 4;
    localparam int B   = 12;
    localparam int Q   = 12289;
    localparam int XB  = 5120;

    typedef struct {
        int a;
        int b;
        int tw;
        int wa;
        int wb;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, ena, enb, wea, web, bf_valid;
    logic [2:0]  addra, addrb, tw_idx;
    logic [15:0] dia, dib, res_a, res_b;

    logic        ld = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [15:0] mem [8];
    logic [15:0] doa, dob, s1a, s1b;

    logic        x_start = 1'b0;
    logic        x_busy [3], x_done [3], x_ena [3], x_enb [3];
    logic        x_wea [3], x_web [3], x_val [3];
    logic [9:0]  x_addra [3], x_addrb [3], x_tw [3];
    logic [15:0] x_dia [3], x_dib [3], x_ra [3], x_rb [3];
    logic [15:0] tick = '0;

    pair_t sbq[$];
    int    gold [N];
    int    checks = 0;
    int    passed = 0;

    always #5 clk = ~clk;

    ntt_ram_sequencer #(.N(N), .WIDTH(16), .BF_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .ram_ena(ena), .ram_enb(enb), .ram_wea(wea), .ram_web(web),
        .ram_addra(addra), .ram_addrb(addrb), .ram_dia(dia), .ram_dib(dib),
        .bf_valid(bf_valid), .tw_idx(tw_idx), .bf_res_a(res_a), .bf_res_b(res_b)
    );

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 7);
        ntt_ram_sequencer #(.N(1024), .WIDTH(16), .BF_LAT(LAT)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(x_start), .busy(x_busy[g]), .done(x_done[g]),
            .ram_ena(x_ena[g]), .ram_enb(x_enb[g]), .ram_wea(x_wea[g]), .ram_web(x_web[g]),
            .ram_addra(x_addra[g]), .ram_addrb(x_addrb[g]), .ram_dia(x_dia[g]), .ram_dib(x_dib[g]),
            .bf_valid(x_val[g]), .tw_idx(x_tw[g]), .bf_res_a(x_ra[g]), .bf_res_b(x_rb[g])
        );
        assign x_ra[g] = tick + 16'(g);
        assign x_rb[g] = ~tick ^ 16'(g);
    end

    always @(posedge clk) tick <= tick + 16'd1;

    // Behavioural dual-port RAM with 1-cycle registered read.
    always @(posedge clk) begin
        if (ld) begin
            mem[ld_addr] <= ld_data;
        end else begin
            if (ena) begin
                if (wea) mem[addra] <= dia;
                doa <= mem[addra];
            end
            if (enb) begin
                if (web) mem[addrb] <= dib;
                dob <= mem[addrb];
            end
        end
    end

    // Two-stage butterfly model: (a+b, a-b) mod q.
    always @(posedge clk) begin
        if (bf_valid) begin
            s1a <= 16'((int'(doa) + int'(dob)) % Q);
            s1b <= 16'((int'(doa) - int'(dob) + Q) % Q);
        end
        res_a <= s1a;
        res_b <= s1b;
    end

    task automatic build_expected();
        int    tw;
        int    a, b;
        pair_t p;
        sbq.delete();
        for (int i = 0; i < N; i++) gold[i] = i;
        tw = 1;
        for (int d = N / 2; d >= 1; d = d / 2) begin
            for (int j = 0; j < N; j += 2 * d) begin
                for (int k = 0; k < d; k++) begin
                    a = gold[j + k];
                    b = gold[j + k + d];
                    p.a = j + k;
                    p.b = j + k + d;
                    p.tw = tw;
                    p.wa = (a + b) % Q;
                    p.wb = (a - b + Q) % Q;
                    gold[j + k] = p.wa;
                    gold[j + k + d] = p.wb;
                    sbq.push_back(p);
                end
                tw++;
            end
        end
    endtask

    task automatic load_ram();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            ld = 1'b1;
            ld_addr = 3'(i);
            ld_data = 16'(i);
        end
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic run_pass(input bit repulse, input string tag);
        pair_t      cur;
        int         done_cnt;
        int         ph;
        bit         inpass, exp_rd, exp_wr, exp_val;
        logic [6:0] obs, expv;
        build_expected();
        load_ram();
        cur = '{default: 0};
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= B * PER + 6; cyc++) begin
            @(negedge clk);
            ph      = (cyc - 1) % PER;
            inpass  = (cyc <= B * PER);
            exp_rd  = inpass && (ph == 0);
            exp_val = inpass && (ph == 1);
            exp_wr  = inpass && (ph == PER - 1);
            obs  = {ena, enb, wea, web, bf_valid, busy, done};
            expv = {exp_rd || exp_wr, exp_rd || exp_wr, exp_wr, exp_wr, exp_val, inpass,
                    cyc == B * PER + 1};
            checks++;
            if (obs !== expv)
                $display("FAIL %s ctrl cyc=%0d got=%b want=%b", tag, cyc, obs, expv);
            else passed++;
            if (done) done_cnt++;
            if (exp_rd) begin
                checks++;
                if (sbq.size() == 0) begin
                    $display("FAIL %s sb_underflow cyc=%0d got=empty want=pair", tag, cyc);
                end else begin
                    cur = sbq.pop_front();
                    if ({addra, addrb, tw_idx} !== {3'(cur.a), 3'(cur.b), 3'(cur.tw)})
                        $display("FAIL %s rd_pair cyc=%0d got=(%0d,%0d,tw%0d) want=(%0d,%0d,tw%0d)",
                                 tag, cyc, addra, addrb, tw_idx, cur.a, cur.b, cur.tw);
                    else passed++;
                end
            end
            if (exp_wr) begin
                checks++;
                if ({addra, addrb, tw_idx, dia, dib} !==
                    {3'(cur.a), 3'(cur.b), 3'(cur.tw), 16'(cur.wa), 16'(cur.wb)})
                    $display("FAIL %s wr cyc=%0d got=(%0d,%0d,tw%0d,%0d,%0d) want=(%0d,%0d,tw%0d,%0d,%0d)",
                             tag, cyc, addra, addrb, tw_idx, dia, dib,
                             cur.a, cur.b, cur.tw, cur.wa, cur.wb);
                else passed++;
                checks++;
                if ({dia, dib} !== {res_a, res_b})
                    $display("FAIL %s passthru cyc=%0d got=%h/%h want=%h/%h", tag, cyc, dia, dib, res_a, res_b);
                else passed++;
            end
            start = repulse && (cyc == 5 || cyc == 30);
        end
        start = 1'b0;
        checks++;
        if (done_cnt != 1) $display("FAIL %s done_count got=%0d want=1", tag, done_cnt);
        else passed++;
        checks++;
        if (sbq.size() != 0) $display("FAIL %s sb_leftover got=%0d want=0", tag, sbq.size());
        else passed++;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (mem[i] !== 16'(gold[i]))
                $display("FAIL %s ram[%0d] got=%0d want=%0d", tag, i, mem[i], gold[i]);
            else passed++;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({busy, done, ena, enb, wea, web, bf_valid, addra, addrb, tw_idx} !== '0)
            $display("FAIL reset_outputs got=%b%b%b%b%b%b%b a=%0d b=%0d tw=%0d want=all zero",
                     busy, done, ena, enb, wea, web, bf_valid, addra, addrb, tw_idx);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({x_busy[i], x_ena[i], x_wea[i], x_val[i], x_addra[i], x_tw[i]} !== '0)
                $display("FAIL reset_x%0d got=%b%b%b%b a=%0d tw=%0d want=all zero",
                         i, x_busy[i], x_ena[i], x_wea[i], x_val[i], x_addra[i], x_tw[i]);
            else passed++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequence();
        run_pass(1'b0, "seq");
    endtask

    task automatic test_start_ignored();
        run_pass(1'b1, "restart");
    endtask

    task automatic test_reset_mid();
        logic [15:0] snap [8];
        pair_t       first;
        bit          seen;
        build_expected();
        first = sbq[0];
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (wea !== 1'b1) $display("FAIL midrst_pre_wr got=%b want=1", wea);
        else passed++;
        snap = mem;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ena, enb, wea, web, bf_valid, busy, done, addra, addrb, tw_idx} !== '0)
            $display("FAIL midrst_outputs got=%b%b%b%b%b%b%b a=%0d b=%0d tw=%0d want=all zero",
                     ena, enb, wea, web, bf_valid, busy, done, addra, addrb, tw_idx);
        else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if (mem != snap) $display("FAIL midrst_ram_written got=changed want=unchanged");
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({ena, wea, addra, addrb, tw_idx} !== {1'b1, 1'b0, 3'(first.a), 3'(first.b), 3'(first.tw)})
            $display("FAIL midrst_restart got=en%b we%b (%0d,%0d,tw%0d) want=en1 we0 (%0d,%0d,tw%0d)",
                     ena, wea, addra, addrb, tw_idx, first.a, first.b, first.tw);
        else passed++;
        seen = 1'b0;
        for (int c = 0; c < B * PER + 10 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) $display("FAIL midrst_done_timeout got=no done want=done");
        else passed++;
    endtask

    task automatic test_latency();
        int         lat [3] = '{1, 3, 7};
        int         wr_cnt [3] = '{0, 0, 0};
        logic [9:0] ra [3], rb [3], rtw [3];
        int         per, ph;
        bit         inpass, exp_rd, exp_wr, exp_val;
        logic [6:0] obs, expv;
        @(negedge clk);
        x_start = 1'b1;
        for (int cyc = 1; cyc <= XB * 9 + 4; cyc++) begin
            @(negedge clk);
            x_start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                per     = 2 + lat[i];
                ph      = (cyc - 1) % per;
                inpass  = (cyc <= XB * per);
                exp_rd  = inpass && (ph == 0);
                exp_val = inpass && (ph == 1);
                exp_wr  = inpass && (ph == per - 1);
                obs  = {x_ena[i], x_enb[i], x_wea[i], x_web[i], x_val[i], x_busy[i], x_done[i]};
                expv = {exp_rd || exp_wr, exp_rd || exp_wr, exp_wr, exp_wr, exp_val, inpass,
                        cyc == XB * per + 1};
                checks++;
                if (obs !== expv)
                    $display("FAIL lat%0d ctrl cyc=%0d got=%b want=%b", lat[i], cyc, obs, expv);
                else passed++;
                if (x_wea[i]) wr_cnt[i]++;
                if (exp_rd) begin
                    ra[i] = x_addra[i];
                    rb[i] = x_addrb[i];
                    rtw[i] = x_tw[i];
                end
                if (exp_wr) begin
                    checks++;
                    if ({x_addra[i], x_addrb[i], x_tw[i], x_dia[i], x_dib[i]} !==
                        {ra[i], rb[i], rtw[i], x_ra[i], x_rb[i]})
                        $display("FAIL lat%0d wr cyc=%0d got=(%0d,%0d,tw%0d,%h,%h) want=(%0d,%0d,tw%0d,%h,%h)",
                                 lat[i], cyc, x_addra[i], x_addrb[i], x_tw[i], x_dia[i], x_dib[i],
                                 ra[i], rb[i], rtw[i], x_ra[i], x_rb[i]);
                    else passed++;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_cnt[i] != XB) $display("FAIL lat%0d write_count got=%0d want=%0d", lat[i], wr_cnt[i], XB);
            else passed++;
        end
        checks++;
        if ({ra[0], rb[0], rtw[0]} !== {10'd1022, 10'd1023, 10'd1023})
            $display("FAIL lat1 last_pair got=(%0d,%0d,tw%0d) want=(1022,1023,tw1023)", ra[0], rb[0], rtw[0]);
        else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequence();
        test_start_ignored();
        test_reset_mid();
        test_latency();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
